// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

  localparam int SA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_e;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder built from two half adders.
// The carries of the two half adders are ORed into the cell carry.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  assign s1   = a ^ b;
  assign c1   = a & b;
  assign s    = s1 ^ cin;
  assign c2   = s1 & cin;
  assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell, WIDTH cycles per sum.
// Valid/ready on both sides; every output comes from a flop.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_e state_q;
  sa_state_e state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic fa_s;
  logic fa_co;

  fa_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = RUN;
      RUN:  if (cnt_q == LAST) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
          carry_q <= fa_co;
          cnt_q   <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: random operands, queue-based
// expected results, and a monitor checking latency, hold and handshakes.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_cin = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_cout;
  logic         busy;
  logic [W-1:0] out_sum;

  int pass_cnt = 0;
  int tot_cnt = 0;
  int cyc = 0;
  int prev_acc = -1;
  bit b2b = 1'b0;
  bit rnd_rdy = 1'b0;

  int exp_q[$];
  int acc_q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int req);
    tot_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  logic pv = 1'b0;
  int held = 0;
  bit post_hs = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
      post_hs = 1'b0;
    end else begin
      if (post_hs) begin
        check("idle_after_hs", int'({in_ready, out_valid}), 2);
        post_hs = 1'b0;
      end
      if (out_valid && !pv) begin
        if (acc_q.size() == 0) check("spurious_valid", 1, 0);
        else check("latency", cyc - acc_q.pop_front(), W);
        held = int'({out_cout, out_sum});
      end else if (out_valid) begin
        check("hold", int'({out_cout, out_sum}), held);
      end
      if (out_valid) check("ready_busy_in_done", int'({in_ready, busy}), 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else check("sum_cout", int'({out_cout, out_sum}), exp_q.pop_front());
        post_hs = 1'b1;
      end
      pv = out_valid;
    end
  end

  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic c, bit keep);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = c;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(int'(a) + int'(b) + int'(c));
    if (b2b && prev_acc >= 0) check("b2b_spacing", cyc + 1 - prev_acc, W + 2);
    prev_acc = cyc + 1;
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    in_cin = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("drain_timeout", 0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", int'(in_ready), 1);
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sum", int'(out_sum), 0);
    check("rst_cout", int'(out_cout), 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(8'h35, 8'h4A, 1'b0, 1'b0);
    drain();
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    drain();
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    drain();

    // Backpressure: result must sit still while out_ready is low.
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b1, 1'b0);
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("bp_valid_seen", int'(out_valid), 1);
    end
    repeat (5) @(negedge clk);
    check("bp_still_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    drain();

    // Abort in the middle of RUN.
    send(8'hA5, 8'h5A, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    check("abort_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1 check("abort_ready", int'({in_ready, out_valid, busy}), 4);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_idle", int'({in_ready, out_valid, busy}), 4);
    send(8'h10, 8'h20, 1'b0, 1'b0);
    drain();

    // Back-to-back with in_valid held high.
    b2b = 1'b1;
    prev_acc = -1;
    for (int i = 0; i < 4; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    end
    in_valid = 1'b0;
    b2b = 1'b0;
    drain();

    // Random operands with random consumer stalls.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    drain();
    check("queues_empty", exp_q.size() + acc_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: in_valid  input  1  operand request valid.
REQ-005 Port: in_ready  output  1  controller can accept an operand request.
REQ-006 Port: in_a  input  WIDTH  operand A.
REQ-007 Port: in_b  input  WIDTH  operand B.
REQ-008 Port: in_cin  input  1  carry-in for the addition.
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: out_sum  output  WIDTH  sum of A + B + cin, modulo 2^WIDTH.
REQ-012 Port: out_cout  output  1  carry out of bit WIDTH-1.
REQ-013 Port: busy  output  1  high in RUN or DONE.

Function
REQ-014 The controller SHALL have a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready it SHALL capture in_a, in_b and in_cin into shift registers and the carry flop, clear the bit counter, and go to RUN.
REQ-016 RUN: each cycle it SHALL drive the LSBs of the A/B shift registers and the carry flop into a single 1-bit full-adder cell, shift the sum bit into the MSB of the sum register, shift A/B right, and load the carry flop with the cell carry.
REQ-017 RUN: the bit counter SHALL count 0..WIDTH-1; on the cycle with count==WIDTH-1 the FSM SHALL go to DONE.
REQ-018 Latency: out_valid SHALL rise on the WIDTH-th rising edge after the accepting edge (8 cycles for WIDTH=8).
REQ-019 DONE: out_valid=1; out_sum and out_cout SHALL hold stable until out_valid&&out_ready; on that handshake the FSM SHALL go to IDLE.
REQ-020 in_ready SHALL be 0 in RUN and DONE; a new request SHALL NOT be accepted in the DONE->IDLE handshake cycle (no combinational path from out_ready to in_ready).
REQ-021 in_valid, in_a, in_b and in_cin SHALL be ignored outside IDLE; the inputs may change during RUN without affecting the result.
REQ-022 out_sum SHALL equal (in_a + in_b + in_cin) mod 2^WIDTH, and out_cout SHALL equal bit WIDTH of the full sum.
REQ-023 Back-to-back throughput SHALL be one result per WIDTH+2 cycles when out_ready is held high.
REQ-024 Outputs SHALL be registered; no output SHALL depend combinationally on any input.

Reset
REQ-025 While rst_n=0, the FSM SHALL be in IDLE with in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, the counter at 0 and the carry flop at 0.
REQ-026 Assertion of rst_n during RUN or DONE SHALL abort the operation immediately with no result produced; the first cycle after deassertion SHALL be IDLE.

Structure
REQ-027 A shared package serial_adder_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default-width constant SA_WIDTH_DEF=8.
REQ-028 The 1-bit adder SHALL be a sub-module fa_cell (two half adders plus OR of their carries), instantiated once.
REQ-029 The counter width SHALL be $clog2(WIDTH).

Verification (WIDTH=8)
REQ-030 A=0x35, B=0x4A, cin=0, out_ready=1 -> out_valid 8 cycles after acceptance, out_sum=0x7F, out_cout=0.
REQ-031 A=0xFF, B=0x01, cin=0 -> out_sum=0x00, out_cout=1; A=0xFF, B=0xFF, cin=1 -> out_sum=0xFF, out_cout=1.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_sum and out_cout held constant and in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-033 Reset mid-RUN (rst_n low at count=3) -> out_valid is never asserted, the next cycle after release is IDLE with in_ready=1, and a following request 0x10+0x20 gives 0x30.
REQ-034 Back-to-back: in_valid held high with 4 operand pairs and out_ready=1 -> 4 correct results at a spacing of 10 cycles, and in_ready is never high in the handshake cycle.
REQ-035 Input change: in_a and in_b toggled randomly during RUN -> the result matches the operands captured at acceptance.
